// File: rtl/lanectrl_delay_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : lanectrl_delay_seq_if
// Brief   : Request/response bundle between a training master and the
//           lanectrl_delay_seq delay-line sequencer.
// Rev     : 1.0 - initial release
// ============================================================================
interface lanectrl_delay_seq_if #(
    parameter int NUM_LANES = 4,
    parameter int TAP_W     = 8
);
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    logic             req_valid;
    logic             req_ready;
    logic [LW-1:0]    req_lane;
    logic             req_load;
    logic             req_dir;
    logic [TAP_W-1:0] req_taps;

    logic             rsp_valid;
    logic             rsp_oor;
    logic             rsp_err;
    logic [TAP_W-1:0] rsp_moved;

    modport master (
        output req_valid, req_lane, req_load, req_dir, req_taps,
        input  req_ready, rsp_valid, rsp_oor, rsp_err, rsp_moved
    );

    modport slave (
        input  req_valid, req_lane, req_load, req_dir, req_taps,
        output req_ready, rsp_valid, rsp_oor, rsp_err, rsp_moved
    );
endinterface
`default_nettype wire

// File: rtl/lanectrl_delay_seq.sv
`default_nettype none
// ============================================================================
// Module  : lanectrl_delay_seq
// Brief   : Multi-lane delay-line sequencer; brackets each LOAD or MOVE burst
//           with an HS_IO_CLK_PAUSE window and tracks per-lane tap position.
// Rev     : 1.0 - initial release
// ============================================================================
module lanectrl_delay_seq #(
    parameter int NUM_LANES  = 4,
    parameter int TAP_W      = 8,
    parameter int PAUSE_PRE  = 2,
    parameter int PAUSE_POST = 2,
    parameter int MOVE_GAP   = 1,
    parameter int LOAD_VALUE = 1
) (
    input  wire                        clk,
    input  wire                        rst_n,
    lanectrl_delay_seq_if.slave        bus,
    output logic [NUM_LANES-1:0]       delay_line_sel_o,
    output logic [NUM_LANES-1:0]       delay_line_load_o,
    output logic [NUM_LANES-1:0]       delay_line_direction_o,
    output logic [NUM_LANES-1:0]       delay_line_move_o,
    output logic [NUM_LANES-1:0]       hs_io_clk_pause_o,
    input  wire  [NUM_LANES-1:0]       delay_line_out_of_range_i,
    output logic [NUM_LANES*TAP_W-1:0] tap_pos_o
);
    localparam int LW      = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int CNT_MAX = (PAUSE_PRE > PAUSE_POST)
                           ? ((PAUSE_PRE  > MOVE_GAP) ? PAUSE_PRE  : MOVE_GAP)
                           : ((PAUSE_POST > MOVE_GAP) ? PAUSE_POST : MOVE_GAP);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [TAP_W-1:0] LV = TAP_W'(LOAD_VALUE);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_SETUP = 3'd2,
        S_MOVE  = 3'd3,
        S_GAP   = 3'd4,
        S_POST  = 3'd5,
        S_RESP  = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [LW-1:0]     lane_q, lane_d;
    logic              load_q, load_d;
    logic              dir_q, dir_d;
    logic [TAP_W-1:0]  taps_q, taps_d;
    logic [TAP_W-1:0]  moved_q, moved_d;
    logic              oor_q, oor_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [NUM_LANES-1:0] lane_oh;
    logic                 lane_oor;
    logic                 req_illegal;

    // One-hot of the registered lane; an illegal index decodes to all-zero.
    always_comb begin
        lane_oh = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_oh[i] = (32'(lane_q) == i);
        end
    end

    assign lane_oor    = |(delay_line_out_of_range_i & lane_oh);
    assign req_illegal = (32'(bus.req_lane) >= NUM_LANES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lane_q  <= '0;
            load_q  <= 1'b0;
            dir_q   <= 1'b0;
            taps_q  <= '0;
            moved_q <= '0;
            oor_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            load_q  <= load_d;
            dir_q   <= dir_d;
            taps_q  <= taps_d;
            moved_q <= moved_d;
            oor_q   <= oor_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        load_d  = load_q;
        dir_d   = dir_q;
        taps_d  = taps_q;
        moved_d = moved_q;
        oor_d   = oor_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    lane_d  = bus.req_lane;
                    load_d  = bus.req_load;
                    dir_d   = bus.req_dir;
                    taps_d  = bus.req_taps;
                    moved_d = '0;
                    oor_d   = 1'b0;
                    err_d   = req_illegal;
                    if (req_illegal || (!bus.req_load && (bus.req_taps == '0))) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_PRE;
                        cnt_d   = CNT_W'(PAUSE_PRE - 1);
                    end
                end
            end
            S_PRE: begin
                if (cnt_q == '0) state_d = S_SETUP;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_SETUP: begin
                if (load_q) begin
                    state_d = S_POST;
                    cnt_d   = CNT_W'(PAUSE_POST - 1);
                end else begin
                    state_d = S_MOVE;
                end
            end
            S_MOVE: begin
                moved_d = moved_q + TAP_W'(1);
                state_d = S_GAP;
                cnt_d   = CNT_W'(MOVE_GAP - 1);
            end
            S_GAP: begin
                // Out-of-range is only meaningful once the gap has settled.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (lane_oor) begin
                    oor_d   = 1'b1;
                    state_d = S_POST;
                    cnt_d   = CNT_W'(PAUSE_POST - 1);
                end else if (moved_q < taps_q) begin
                    state_d = S_MOVE;
                end else begin
                    state_d = S_POST;
                    cnt_d   = CNT_W'(PAUSE_POST - 1);
                end
            end
            S_POST: begin
                if (cnt_q == '0) state_d = S_RESP;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        hs_io_clk_pause_o      = '0;
        delay_line_sel_o       = '0;
        delay_line_direction_o = '0;
        delay_line_load_o      = '0;
        delay_line_move_o      = '0;
        if (state_q inside {S_PRE, S_SETUP, S_MOVE, S_GAP, S_POST}) begin
            hs_io_clk_pause_o = lane_oh;
        end
        if (state_q inside {S_SETUP, S_MOVE, S_GAP}) begin
            delay_line_sel_o       = lane_oh;
            delay_line_direction_o = dir_q ? lane_oh : '0;
        end
        if ((state_q == S_SETUP) && load_q) begin
            delay_line_load_o = lane_oh;
        end
        if (state_q == S_MOVE) begin
            delay_line_move_o = lane_oh;
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_oor   = (state_q == S_RESP) && oor_q;
    assign bus.rsp_err   = (state_q == S_RESP) && err_q;
    assign bus.rsp_moved = (state_q == S_RESP) ? moved_q : '0;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [TAP_W-1:0] pos_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pos_q <= LV;
            end else if (lane_oh[i] && (state_q == S_SETUP) && load_q) begin
                pos_q <= LV;
            end else if (lane_oh[i] && (state_q == S_MOVE)) begin
                if (dir_q && (pos_q != '1)) begin
                    pos_q <= pos_q + TAP_W'(1);
                end else if (!dir_q && (pos_q != '0)) begin
                    pos_q <= pos_q - TAP_W'(1);
                end
            end
        end

        assign tap_pos_o[i*TAP_W +: TAP_W] = pos_q;
    end
endmodule
`default_nettype wire

// File: tb/tb_lanectrl_delay_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_lanectrl_delay_seq
// Brief   : Randomised self-checking bench; expected waveforms come from a
//           timeline built out of the pause/move/gap lengths.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_lanectrl_delay_seq;
    localparam int NL   = 5;
    localparam int TW   = 8;
    localparam int PRE  = 2;
    localparam int POST = 2;
    localparam int GAP  = 1;
    localparam int LV   = 1;
    localparam int LW   = 3;
    localparam int MAXC = 1024;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lanectrl_delay_seq_if #(.NUM_LANES(NL), .TAP_W(TW)) bus();

    logic [NL-1:0]    sel_w, load_w, dir_w, move_w, pause_w, oor_r;
    logic [NL*TW-1:0] tap_pos_w;

    lanectrl_delay_seq #(
        .NUM_LANES(NL), .TAP_W(TW), .PAUSE_PRE(PRE), .PAUSE_POST(POST),
        .MOVE_GAP(GAP), .LOAD_VALUE(LV)
    ) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .bus                       (bus),
        .delay_line_sel_o          (sel_w),
        .delay_line_load_o         (load_w),
        .delay_line_direction_o    (dir_w),
        .delay_line_move_o         (move_w),
        .hs_io_clk_pause_o         (pause_w),
        .delay_line_out_of_range_i (oor_r),
        .tap_pos_o                 (tap_pos_w)
    );

    int n_checks = 0;
    int n_errors = 0;
    int model_tap[NL];
    bit e_pause[MAXC], e_sel[MAXC], e_ld[MAXC], e_mv[MAXC], e_gl[MAXC];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [NL*TW-1:0] model_taps();
        logic [NL*TW-1:0] v;
        v = '0;
        for (int i = 0; i < NL; i++) v[i*TW +: TW] = TW'(model_tap[i]);
        return v;
    endfunction

    // oor_k > 0: addressed lane reports out-of-range from the cycle after the k-th move.
    task automatic run_txn(input int lane, input bit load, input bit d, input int taps, input int oor_k);
        int r, c, moved, force_from;
        bit exp_err, exp_oor, skip, aborted;
        logic [NL-1:0] oh, noise;
        logic [5*NL-1:0] exp_vec;

        for (int i = 0; i < MAXC; i++) begin
            e_pause[i] = 0; e_sel[i] = 0; e_ld[i] = 0; e_mv[i] = 0; e_gl[i] = 0;
        end
        exp_err    = (lane >= NL);
        skip       = exp_err || (!load && taps == 0);
        oh         = exp_err ? '0 : (NL'(1) << lane);
        moved      = 0;
        exp_oor    = 0;
        force_from = MAXC;

        if (skip) begin
            r = 1;
        end else begin
            c = 1;
            repeat (PRE) begin e_pause[c] = 1; c++; end
            e_pause[c] = 1; e_sel[c] = 1; e_ld[c] = load; c++;
            if (!load) begin
                aborted = 0;
                for (int m = 1; m <= taps && !aborted; m++) begin
                    e_pause[c] = 1; e_sel[c] = 1; e_mv[c] = 1; c++; moved++;
                    if (oor_k == m) force_from = c;
                    for (int g = 0; g < GAP; g++) begin
                        e_pause[c] = 1; e_sel[c] = 1; e_gl[c] = (g == GAP - 1); c++;
                    end
                    if (oor_k == m) begin aborted = 1; exp_oor = 1; end
                end
            end
            repeat (POST) begin e_pause[c] = 1; c++; end
            r = c;
            if (load) model_tap[lane] = LV;
            else repeat (moved) begin
                if (d) model_tap[lane] = (model_tap[lane] < 255) ? model_tap[lane] + 1 : 255;
                else   model_tap[lane] = (model_tap[lane] > 0)   ? model_tap[lane] - 1 : 0;
            end
        end

        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_lane  = LW'(lane);
        bus.req_load  = load;
        bus.req_dir   = d;
        bus.req_taps  = TW'(taps);
        oor_r         = NL'($urandom);
        @(negedge clk);
        check("ready_idle", bus.req_ready, 1);

        for (int c2 = 1; c2 <= r; c2++) begin
            @(posedge clk); #1;
            bus.req_valid = 1'b0;
            bus.req_lane  = LW'($urandom);
            bus.req_taps  = TW'($urandom);
            noise = NL'($urandom);
            if (c2 >= force_from) noise = noise | oh;
            else if (e_gl[c2])    noise = noise & ~oh;
            oor_r = noise;
            @(negedge clk);
            exp_vec = {{NL{e_pause[c2]}} & oh, {NL{e_sel[c2]}} & oh,
                       {NL{e_sel[c2] & d}} & oh, {NL{e_ld[c2]}} & oh, {NL{e_mv[c2]}} & oh};
            check("strobes", {pause_w, sel_w, dir_w, load_w, move_w}, exp_vec);
            check("ready_busy", bus.req_ready, 0);
            check("rsp_valid", bus.rsp_valid, (c2 == r));
            if (c2 == r) begin
                check("rsp_oor", bus.rsp_oor, exp_oor);
                check("rsp_err", bus.rsp_err, exp_err);
                check("rsp_moved", bus.rsp_moved, moved);
            end
        end

        @(posedge clk); #1;
        oor_r = '0;
        @(negedge clk);
        check("ready_after", bus.req_ready, 1);
        check("rsp_idle", bus.rsp_valid, 0);
        check("tap_pos", tap_pos_w, model_taps());
    endtask

    initial begin
        int lane, taps, ok;
        bit ld, d;

        bus.req_valid = 1'b0;
        bus.req_lane  = '0;
        bus.req_load  = 1'b0;
        bus.req_dir   = 1'b0;
        bus.req_taps  = '0;
        oor_r         = '0;
        for (int i = 0; i < NL; i++) model_tap[i] = LV;

        repeat (3) @(negedge clk);
        check("rst_strobes", {pause_w, sel_w, dir_w, load_w, move_w}, 0);
        check("rst_rsp", {bus.rsp_valid, bus.rsp_oor, bus.rsp_err, bus.rsp_moved}, 0);
        check("rst_tap", tap_pos_w, model_taps());
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_rel", bus.req_ready, 1);

        run_txn(2, 0, 1, 3, 0);
        run_txn(1, 1, 0, 7, 0);
        run_txn(0, 0, 0, 4, 0);
        run_txn(0, 0, 1, 5, 2);
        run_txn(5, 0, 1, 3, 0);
        run_txn(3, 0, 1, 0, 0);
        run_txn(4, 0, 1, 255, 0);

        // Reset in the first GAP cycle of a 3-tap sequence on lane 2.
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_lane = 3'd2; bus.req_load = 1'b0;
        bus.req_dir = 1'b1; bus.req_taps = 8'd3; oor_r = '0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        check("pre_rst_sel", sel_w, 5'b00100);
        rst_n = 1'b0;
        #1;
        check("arst_strobes", {pause_w, sel_w, dir_w, load_w, move_w}, 0);
        check("arst_tap", tap_pos_w, {NL{TW'(LV)}});
        check("arst_rsp", bus.rsp_valid, 0);
        repeat (2) begin
            @(negedge clk);
            check("arst_hold", {bus.rsp_valid, pause_w, sel_w, move_w}, 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < NL; i++) model_tap[i] = LV;
        @(negedge clk);
        check("ready_post_rst", bus.req_ready, 1);
        run_txn(2, 0, 1, 3, 0);

        for (int n = 0; n < 40; n++) begin
            lane = $urandom_range(0, 7);
            ld   = ($urandom_range(0, 3) == 0);
            d    = 1'($urandom);
            taps = $urandom_range(0, 12);
            ok   = 0;
            if (!ld && taps > 0 && $urandom_range(0, 2) == 0) ok = $urandom_range(1, taps);
            run_txn(lane, ld, d, taps, ok);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
